smpl_avg: RTL
=============

SMPL_AVG -- requirements
Module: smpl_avg

Interface
REQ-001 Parameter N_SMPL, default 8: samples per average; legal range 1..15.
REQ-002 clk  input  1  clock; all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 smpl_vld  input  1  sample strobe; accepted only while smpl_rdy=1.
REQ-005 smpl  input  12  signed sample (two's complement).
REQ-006 smpl_rdy  output  1  high when block can accept a sample.
REQ-007 clr  input  1  synchronous abort of the current window.
REQ-008 div_go  output  1  one-cycle start pulse to the downstream signed divider.
REQ-009 div_dividend  output  16  signed window sum, registered.
REQ-010 div_divisor  output  16  signed, constant N_SMPL.
REQ-011 div_quotient  input  16  signed divider result, valid while div_rdy=1.
REQ-012 div_rdy  input  1  divider done; cleared by divider on the edge that samples div_go, then held high until next go.
REQ-013 avg  output  16  signed average, registered, held between updates.
REQ-014 avg_vld  output  1  one-cycle pulse when avg updates.

Function
REQ-015 FSM states SHALL be ACCUM, ISSUE, WAIT; reset state ACCUM.
REQ-016 ACCUM: smpl_rdy=1; on smpl_vld, sum += sign-extended smpl (16 bit), cnt += 1.
REQ-017 ACCUM -> ISSUE on the edge accepting sample number N_SMPL; sum then holds the full window.
REQ-018 ISSUE: div_go=1 for exactly one cycle, div_dividend=window sum, smpl_rdy=0; next state WAIT.
REQ-019 WAIT: smpl_rdy=0; ignore div_rdy in the first WAIT cycle is not required since divider clears div_rdy on the go edge; exit on first cycle with div_rdy=1.
REQ-020 WAIT with div_rdy=1: avg <= div_quotient, avg_vld=1 next cycle, sum/cnt <= 0, state -> ACCUM.
REQ-021 smpl_vld while smpl_rdy=0 SHALL be dropped without side effect.
REQ-022 div_go SHALL never be asserted outside ISSUE; div_divisor SHALL never be 0.
REQ-023 Sum of N_SMPL 12-bit samples SHALL fit 16 bits without overflow (max |sum| 30720).
REQ-024 clr in ACCUM: sum/cnt <= 0 that edge; sample on same cycle discarded.
REQ-025 clr in ISSUE or WAIT: set discard flag; divider run completes; on div_rdy return to ACCUM with avg unchanged, avg_vld=0, flag cleared.
REQ-026 Latency: last sample edge -> div_go next cycle -> avg_vld one cycle after div_rdy sampled.
REQ-027 Rounding off: result truncates toward zero (divider behaviour).

Reset
REQ-028 rst_n low: state=ACCUM, sum=0, cnt=0, discard=0, div_go=0, div_dividend=0, avg=0, avg_vld=0; smpl_rdy=1 after release.
REQ-029 Reset mid-WAIT: block restarts in ACCUM; divider reset by the same rst_n.

Configuration
REQ-030 AVG_ROUND_EN defined: div_dividend = sum + N_SMPL/2 if sum>=0, else sum - N_SMPL/2 (integer N_SMPL/2), giving round-half-away-from-zero.
REQ-031 AVG_ROUND_EN undefined: div_dividend = sum exactly.

Verification
REQ-032 N_SMPL=4, samples 10,20,30,40 -> div_go one cycle, dividend=100, divisor=4; divider returns 25 -> avg=25, avg_vld one pulse.
REQ-033 N_SMPL=4, samples -5,-6,-7,-8 -> dividend -26, avg=-6; with AVG_ROUND_EN dividend -28, avg=-7.
REQ-034 smpl_vld held high through ISSUE/WAIT with value 2047 -> sum unaffected, next window starts from 0 after avg_vld.
REQ-035 clr during WAIT -> no avg_vld, avg keeps previous value, next window of 1,1,1,1 gives avg=1.
REQ-036 N_SMPL=15, fifteen samples of -2048 -> dividend -30720, avg=-2048, no overflow.
REQ-037 rst_n asserted mid-WAIT -> all outputs at reset values, smpl_rdy=1 after release, next full window averages correctly.

Source files
------------

// File: rtl/smpl_avg.sv
// ---------------------------------------------------------------------------
// smpl_avg
//
// Purpose:
//   Sums windows of N_SMPL signed 12-bit samples and hands each window sum to
//   an external signed divider. The divider quotient becomes the
//   registered window average. A clear input aborts the window in progress.
//   If the clear arrives while the divider is busy, that divider result is
//   dropped.
//
// Optional feature:
//   AVG_ROUND_EN  when defined, the value sent to the divider is biased by
//                 N_SMPL/2 away from zero. The truncating divider then
//                 produces round-half-away-from-zero. When undefined, the
//                 raw window sum is sent.
//
// Parameters:
//   N_SMPL          samples per average, legal range 1..15
//
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   i_smpl_vld      sample strobe, accepted only while o_smpl_rdy is high
//   i_smpl          signed 12-bit sample
//   o_smpl_rdy      block can accept a sample (accumulate state)
//   i_clr           synchronous abort of the current window
//   o_div_go        one-cycle start pulse to the divider
//   o_div_dividend  registered signed window sum (optionally biased)
//   o_div_divisor   constant N_SMPL
//   i_div_quotient  signed divider result, valid while i_div_rdy is high
//   i_div_rdy       divider done flag
//   o_avg           registered signed average, held between updates
//   o_avg_vld       one-cycle pulse when o_avg updates
// ---------------------------------------------------------------------------
module smpl_avg #(
  parameter int N_SMPL = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_smpl_vld,
  input  logic signed [11:0] i_smpl,
  output logic               o_smpl_rdy,
  input  logic               i_clr,
  output logic               o_div_go,
  output logic signed [15:0] o_div_dividend,
  output logic signed [15:0] o_div_divisor,
  input  logic signed [15:0] i_div_quotient,
  input  logic               i_div_rdy,
  output logic signed [15:0] o_avg,
  output logic               o_avg_vld
);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [3:0]        LAST_CNT = 4'(N_SMPL - 1);
  localparam logic signed [15:0] DIVISOR = 16'(N_SMPL);
`ifdef AVG_ROUND_EN
  localparam logic signed [15:0] HALF    = 16'(N_SMPL / 2);
`endif

  logic [1:0]         r_state;
  logic signed [15:0] r_sum;
  logic [3:0]         r_cnt;
  logic               r_discard;
  logic               r_div_go;
  logic signed [15:0] r_div_dividend;
  logic signed [15:0] r_avg;
  logic               r_avg_vld;

  logic signed [15:0] w_smpl_ext;
  logic signed [15:0] w_sum_next;
  logic signed [15:0] w_dividend_next;
  logic               w_last;
  logic               w_drop_result;

  // The running sum is carried in 16 bits. Fifteen full-scale 12-bit samples
  // reach at most 30720 in magnitude, so the sum never wraps.
  always_comb begin
    w_smpl_ext = {{4{i_smpl[11]}}, i_smpl};
    w_sum_next = r_sum + w_smpl_ext;
    w_last     = (r_cnt == LAST_CNT);
  end

  // The divider truncates toward zero. Biasing the dividend by half the
  // divisor, in the direction of its sign, turns that into
  // round-half-away-from-zero. The bias is applied to the completed sum,
  // so it is added once per window.
`ifdef AVG_ROUND_EN
  always_comb begin
    w_dividend_next = w_sum_next[15] ? (w_sum_next - HALF) : (w_sum_next + HALF);
  end
`else
  always_comb begin
    w_dividend_next = w_sum_next;
  end
`endif

  // A clear seen in the same cycle that the divider finishes also drops
  // that result. The abort therefore takes effect even if it lands on the
  // last waiting cycle.
  always_comb begin
    w_drop_result = r_discard | i_clr;
  end

  // Main control. ACCUM accepts samples. The edge that accepts the last
  // sample of a window also registers the dividend and raises div_go. As a
  // result, div_go is high exactly for the single ISSUE cycle. WAIT holds
  // off new samples until the divider reports done. It then either
  // publishes the quotient or, after an abort, drops it silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_ACCUM;
      r_sum          <= '0;
      r_cnt          <= '0;
      r_discard      <= 1'b0;
      r_div_go       <= 1'b0;
      r_div_dividend <= '0;
      r_avg          <= '0;
      r_avg_vld      <= 1'b0;
    end else begin
      r_div_go  <= 1'b0;
      r_avg_vld <= 1'b0;
      case (r_state)
        ST_ACCUM: begin
          if (i_clr) begin
            r_sum <= '0;
            r_cnt <= '0;
          end else if (i_smpl_vld) begin
            r_sum <= w_sum_next;
            r_cnt <= r_cnt + 4'd1;
            if (w_last) begin
              r_div_go       <= 1'b1;
              r_div_dividend <= w_dividend_next;
              r_state        <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (i_clr) begin
            r_discard <= 1'b1;
          end
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_div_rdy) begin
            if (!w_drop_result) begin
              r_avg     <= i_div_quotient;
              r_avg_vld <= 1'b1;
            end
            r_sum     <= '0;
            r_cnt     <= '0;
            r_discard <= 1'b0;
            r_state   <= ST_ACCUM;
          end else if (i_clr) begin
            r_discard <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

  // Outputs. Ready is decoded straight from the state, so samples offered
  // during ISSUE or WAIT are dropped with no side effect.
  always_comb begin
    o_smpl_rdy     = (r_state == ST_ACCUM);
    o_div_go       = r_div_go;
    o_div_dividend = r_div_dividend;
    o_div_divisor  = DIVISOR;
    o_avg          = r_avg;
    o_avg_vld      = r_avg_vld;
  end

endmodule
